mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage; consumes the EX→MEM register bundle (read/write/noMEM flags, address, value, func3 address mode, rd) and produces the writeback bundle.
- Performs byte/half/word loads and stores against a single-port data memory with a req/ack handshake.
- Splits word-crossing (misaligned) accesses into two aligned beats.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- width, 32, data/address width
- rsWidth, 5, register index width
- maxWait, 255, ack timeout in cycles; range 1..255 (8-bit counter)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- readIn  in  1  load request from EX
- writeIn  in  1  store request from EX
- noMEMIn  in  1  pass-through (ALU/jump result), no memory access
- valueIn  in  width  ALU/link result for pass-through; store data for stores
- addressIn  in  width  effective byte address
- addressModeIn  in  3  func3: 0 B, 1 H, 2 W, 4 BU, 5 HU
- rdIn  in  rsWidth  destination register
- memReq  out  1  memory request, held until memAck
- memWe  out  1  1=write beat
- memAddr  out  width  word-aligned address ({addr[31:2],2'b00})
- memWdata  out  width  lane-shifted store data
- memByteEn  out  4  active byte lanes
- memRdata  in  width  read data, valid with memAck
- memAck  in  1  single-cycle completion of current beat
- wbValueOut  out  width  writeback value
- wbRdOut  out  rsWidth  writeback register
- wbEnOut  out  1  writeback valid (0 for stores, or when rd==0)
- stallOut  out  1  freeze IF/ID/EX
- faultOut  out  1  one-cycle pulse: ack timeout, or misaligned access under MISALIGN_TRAP_EN

Behaviour:
- Reset: all outputs 0; FSM in IDLE; wait counter 0. Reset mid-transaction abandons it: memReq drops on the next edge and no writeback occurs.
- Input priority: writeIn > readIn > noMEMIn. All three 0 = bubble, giving wbEnOut=0 next cycle.
- Pass-through (noMEMIn, IDLE):
  - latency 1: wbValueOut<=valueIn, wbRdOut<=rdIn, wbEnOut<=(rdIn!=0).
  - no stall.
- Memory op accepted in IDLE:
  - stallOut=1 combinationally in the same cycle; memReq=1 in the same cycle.
  - Inputs are captured into internal registers at that edge; upstream holds its values while stalled.
- Beat plan:
  - offset=addr[1:0], size=1/2/4 bytes.
  - Second beat needed iff offset+size>4: H with offset 3, or W with offset≠0.
  - Beat0 byteEn = size mask <<offset (truncated to 4). Beat1 byteEn = overflow lanes, at memAddr+4.
- FSM states:
  - IDLE→BEAT0 on a memory op.
  - BEAT0→BEAT1 on memAck if split, else →DONE.
  - BEAT1→DONE on memAck.
  - DONE→IDLE unconditionally; stallOut=0 in DONE.
  - Writeback registers load on the DONE edge. Load-to-writeback = (beats + ack waits + 1) cycles after acceptance.
- Stall window: stallOut=1 in BEAT0/BEAT1 and in IDLE when accepting a memory op.
- Loads:
  - memRdata lanes of each beat are assembled into a 32-bit little-endian value.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
  - Unused func3 (3,6,7) on a load is treated as W.
- Stores:
  - memWdata = storeData<<(8*offset) for beat0; storeData>>(8*(4-offset)) for beat1.
  - Store func3 >2 is treated as W.
  - wbEnOut=0 for stores.
- Timeout: a wait counter resets each beat. On reaching maxWait without memAck:
  - faultOut pulses 1 cycle, FSM→IDLE, no writeback, memReq drops.
- memAck in IDLE/DONE is ignored.
- memReq, memAddr, memWe, memWdata and memByteEn are stable while memReq=1.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A split-required access is not issued: memReq stays 0.
  - faultOut pulses 1 the cycle after acceptance, stallOut=0 that cycle, no writeback.
  - BEAT1 state is compiled out.
- Undefined: split behaviour as above.

Decomposition:
- Shared package eon_mem_pkg:
  - func3 size constants (MEM_B=0, MEM_H=1, MEM_W=2, MEM_BU=4, MEM_HU=5).
  - mem_state_t enum {IDLE, BEAT0, BEAT1, DONE}.
  - WORD_BYTES=4.
- One sub-module, mem_lane_align: combinational store shift/byteEn generation and load assembly/extension.

Test Plan:
- noMEMIn=1, valueIn=0x1234, rdIn=5 → next cycle wbValueOut=0x1234, wbRdOut=5, wbEnOut=1, stallOut never 1.
- Load LB, addr 0x103, memAck after 2 cycles with memRdata=0x80FFFFFF → memAddr=0x100, byteEn=4'b1000, wbValueOut=0xFFFFFF80; LBU of the same access gives 0x00000080.
- Store SW, addr 0x202, data 0xAABBCCDD →
  - beat0: memAddr 0x200, byteEn 4'b1100, wdata[31:16]=0xCCDD.
  - beat1: memAddr 0x204, byteEn 4'b0011, wdata[15:0]=0xAABB.
  - wbEnOut=0.
- Load LW, addr 0x1, beat0 rdata=0x44332211, beat1 rdata=0x88776655 → wbValueOut=0x55443322; with MISALIGN_TRAP_EN → faultOut pulse, memReq never 1.
- Load LH, addr 0x10, memAck withheld for maxWait cycles → faultOut pulse, stallOut returns 0, wbEnOut=0.
- Load accepted and reset asserted in BEAT0 → next cycle memReq=0, stallOut=0, wbEnOut=0; a subsequent late memAck has no effect.

Source files
------------

// File: rtl/eon_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - func3 access-size encodings (MEM_B/H/W/BU/HU)
//   - mem_state_t: FSM states of the memory sequencer
//   - WORD_BYTES: bytes per memory word
//   - size_mask(): byte-lane mask of an access before it is shifted by the address offset
package eon_mem_pkg;

    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

    // Stores only know B/H/W (anything above 2 is a word); loads also have BU/HU.
    // Unused encodings fall back to a full word.
    function automatic logic [WORD_BYTES-1:0] size_mask(input logic [2:0] mode,
                                                        input logic       is_write);
        logic [WORD_BYTES-1:0] m;
        m = 4'b1111;
        if (is_write) begin
            case (mode)
                MEM_B:   m = 4'b0001;
                MEM_H:   m = 4'b0011;
                default: m = 4'b1111;
            endcase
        end else begin
            case (mode)
                MEM_B, MEM_BU: m = 4'b0001;
                MEM_H, MEM_HU: m = 4'b0011;
                default:       m = 4'b1111;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the MEM stage.
//   offset, addressMode, isWrite : describe the access
//   beat                         : 0 = first (low) word, 1 = second (overflow) word
//   storeData -> wdata, byteEn   : lane-shifted store data and active lanes for this beat
//   split                        : access crosses a word boundary and needs two beats
//   rdata0, rdata1 -> loadValue  : read words of both beats assembled and sign/zero-extended
module mem_lane_align
    import eon_mem_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [1:0]            offset,
    input  logic [2:0]            addressMode,
    input  logic                  isWrite,
    input  logic                  beat,
    input  logic [width-1:0]      storeData,
    output logic [width-1:0]      wdata,
    output logic [WORD_BYTES-1:0] byteEn,
    output logic                  split,
    input  logic [width-1:0]      rdata0,
    input  logic [width-1:0]      rdata1,
    output logic [width-1:0]      loadValue
);

    logic [2*WORD_BYTES-1:0] lanes;
    logic [5:0]              lo_shift;
    logic [5:0]              hi_shift;
    logic [2*width-1:0]      pair;
    logic [width-1:0]        raw;

    always_comb begin
        // Upper half of the shifted mask are the lanes spilling into the next word.
        lanes    = {{WORD_BYTES{1'b0}}, size_mask(addressMode, isWrite)} << offset;
        split    = |lanes[2*WORD_BYTES-1:WORD_BYTES];
        byteEn   = beat ? lanes[2*WORD_BYTES-1:WORD_BYTES] : lanes[WORD_BYTES-1:0];

        lo_shift = {1'b0, offset, 3'b000};
        hi_shift = 6'd32 - lo_shift;
        wdata    = beat ? (storeData >> hi_shift) : (storeData << lo_shift);

        // Little-endian: the second word supplies the bytes above the first.
        pair     = {rdata1, rdata0} >> lo_shift;
        raw      = pair[width-1:0];

        case (addressMode)
            MEM_B:   loadValue = {{(width-8){raw[7]}}, raw[7:0]};
            MEM_H:   loadValue = {{(width-16){raw[15]}}, raw[15:0]};
            MEM_BU:  loadValue = {{(width-8){1'b0}}, raw[7:0]};
            MEM_HU:  loadValue = {{(width-16){1'b0}}, raw[15:0]};
            default: loadValue = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: turns the EX->MEM bundle into the writeback bundle, issuing byte/half/word
// loads and stores to a single-port data memory over a req/ack handshake. Word-crossing accesses
// are split into two aligned beats; the upstream pipeline is stalled while a beat is pending.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   readIn/writeIn/noMEMIn      op select (write > read > pass-through)
//   valueIn, addressIn          pass-through/store value, byte address
//   addressModeIn, rdIn         func3 access mode, destination register
//   memReq/memWe/memAddr/memWdata/memByteEn/memRdata/memAck   data memory port
//   wbValueOut/wbRdOut/wbEnOut  writeback bundle
//   stallOut                    freezes IF/ID/EX
//   faultOut                    one-cycle pulse on ack timeout (or trapped misaligned access)
// Build option: define MISALIGN_TRAP_EN to fault on word-crossing accesses instead of splitting.
module mem_stage
    import eon_mem_pkg::*;
#(
    parameter int width   = 32,
    parameter int rsWidth = 5,
    parameter int maxWait = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               readIn,
    input  logic               writeIn,
    input  logic               noMEMIn,
    input  logic [width-1:0]   valueIn,
    input  logic [width-1:0]   addressIn,
    input  logic [2:0]         addressModeIn,
    input  logic [rsWidth-1:0] rdIn,
    output logic               memReq,
    output logic               memWe,
    output logic [width-1:0]   memAddr,
    output logic [width-1:0]   memWdata,
    output logic [3:0]         memByteEn,
    input  logic [width-1:0]   memRdata,
    input  logic               memAck,
    output logic [width-1:0]   wbValueOut,
    output logic [rsWidth-1:0] wbRdOut,
    output logic               wbEnOut,
    output logic               stallOut,
    output logic               faultOut
);

    localparam logic [7:0] WaitLimit = 8'(maxWait - 1);

    mem_state_t         state_q;
    logic [7:0]         wait_q;
    logic               fault_q;
    logic               write_q;
    logic [width-1:0]   addr_q;
    logic [2:0]         mode_q;
    logic [width-1:0]   data_q;
    logic [rsWidth-1:0] rd_q;
    logic [width-1:0]   rdata0_q;
    logic [width-1:0]   rdata1_q;

    logic               accept;
    logic               trap_split;
    logic               pass_en;
    logic               in_beat;
    logic               cur_write;
    logic [width-1:0]   cur_addr;
    logic [2:0]         cur_mode;
    logic [width-1:0]   cur_data;
    logic [width-1:0]   lane_wdata;
    logic [3:0]         lane_be;
    logic               split;
    logic [width-1:0]   load_value;
    logic [width-1:0]   beat_off;

    // The cycle after a fault the upstream still presents the faulting op; it must not be
    // re-accepted, so that cycle is treated as a bubble and the stall is released.
    assign accept  = (state_q == IDLE) && !reset && !fault_q && (writeIn || readIn);
    assign pass_en = noMEMIn && !writeIn && !readIn && !fault_q && (rdIn != '0);
    assign in_beat = (state_q == BEAT0) || (state_q == BEAT1);

    // In IDLE the request is issued straight from the inputs so it starts in the accept cycle.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = writeIn;
            cur_addr  = addressIn;
            cur_mode  = addressModeIn;
            cur_data  = valueIn;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_mode  = mode_q;
            cur_data  = data_q;
        end
    end

    mem_lane_align #(
        .width(width)
    ) u_align (
        .offset     (cur_addr[1:0]),
        .addressMode(cur_mode),
        .isWrite    (cur_write),
        .beat       (state_q == BEAT1),
        .storeData  (cur_data),
        .wdata      (lane_wdata),
        .byteEn     (lane_be),
        .split      (split),
        .rdata0     (rdata0_q),
        .rdata1     (rdata1_q),
        .loadValue  (load_value)
    );

`ifdef MISALIGN_TRAP_EN
    assign trap_split = accept && split;
`else
    assign trap_split = 1'b0;
`endif

    always_comb begin
        beat_off  = (state_q == BEAT1) ? width'(WORD_BYTES) : {width{1'b0}};
        memReq    = (accept && !trap_split) || in_beat;
        memWe     = memReq && cur_write;
        memAddr   = memReq ? ({cur_addr[width-1:2], 2'b00} + beat_off) : '0;
        memWdata  = memReq ? lane_wdata : '0;
        memByteEn = memReq ? lane_be : 4'b0000;
        stallOut  = accept || in_beat;
        faultOut  = fault_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            fault_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            mode_q     <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            wbValueOut <= '0;
            wbRdOut    <= '0;
            wbEnOut    <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= writeIn;
                        addr_q  <= addressIn;
                        mode_q  <= addressModeIn;
                        data_q  <= valueIn;
                        rd_q    <= rdIn;
                        wait_q  <= '0;
                        wbEnOut <= 1'b0;
                        if (trap_split) fault_q <= 1'b1;
                        else            state_q <= BEAT0;
                    end else begin
                        wbValueOut <= valueIn;
                        wbRdOut    <= rdIn;
                        wbEnOut    <= pass_en;
                    end
                end
                BEAT0: begin
                    if (memAck) begin
                        rdata0_q <= memRdata;
                        wait_q   <= '0;
`ifdef MISALIGN_TRAP_EN
                        state_q  <= DONE;
`else
                        state_q  <= split ? BEAT1 : DONE;
`endif
                    end else if (wait_q == WaitLimit) begin
                        state_q <= IDLE;
                        fault_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
`ifndef MISALIGN_TRAP_EN
                BEAT1: begin
                    if (memAck) begin
                        rdata1_q <= memRdata;
                        wait_q   <= '0;
                        state_q  <= DONE;
                    end else if (wait_q == WaitLimit) begin
                        state_q <= IDLE;
                        fault_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
`endif
                DONE: begin
                    // Inputs here are the op just completed (stall released), so ignore them.
                    state_q    <= IDLE;
                    wbValueOut <= write_q ? '0 : load_value;
                    wbRdOut    <= rd_q;
                    wbEnOut    <= !write_q && (rd_q != '0);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected beats and writebacks are queued when an op is driven
// and popped as the DUT presents each beat / writeback.
module tb_mem_stage;

    localparam int MAXW = 16;

    logic        clk;
    logic        reset;
    logic        readIn, writeIn, noMEMIn;
    logic [31:0] valueIn, addressIn;
    logic [2:0]  addressModeIn;
    logic [4:0]  rdIn;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memByteEn;
    logic [31:0] memRdata;
    logic        memAck;
    logic [31:0] wbValueOut;
    logic [4:0]  wbRdOut;
    logic        wbEnOut, stallOut, faultOut;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [31:0] rdata;
        int          waits;
    } beat_t;

    typedef struct {
        logic [31:0] val;
        logic [4:0]  rd;
    } wb_t;

    beat_t beat_q[$];
    wb_t   wb_q[$];

    mem_stage #(
        .width  (32),
        .rsWidth(5),
        .maxWait(MAXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .readIn       (readIn),
        .writeIn      (writeIn),
        .noMEMIn      (noMEMIn),
        .valueIn      (valueIn),
        .addressIn    (addressIn),
        .addressModeIn(addressModeIn),
        .rdIn         (rdIn),
        .memReq       (memReq),
        .memWe        (memWe),
        .memAddr      (memAddr),
        .memWdata     (memWdata),
        .memByteEn    (memByteEn),
        .memRdata     (memRdata),
        .memAck       (memAck),
        .wbValueOut   (wbValueOut),
        .wbRdOut      (wbRdOut),
        .wbEnOut      (wbEnOut),
        .stallOut     (stallOut),
        .faultOut     (faultOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                             input logic [31:0] wdata, input logic [31:0] wmask,
                             input logic [31:0] rdata, input int waits);
        beat_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata; b.wmask = wmask;
        b.rdata = rdata; b.waits = waits;
        beat_q.push_back(b);
    endtask

    task automatic push_wb(input logic [31:0] val, input logic [4:0] rd);
        wb_t w;
        w.val = val; w.rd = rd;
        wb_q.push_back(w);
    endtask

    task automatic drive_op(input logic we, input logic re, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        writeIn = we; readIn = re; noMEMIn = 1'b0;
        addressModeIn = mode; addressIn = addr; valueIn = data; rdIn = rd;
    endtask

    task automatic bubble();
        writeIn = 1'b0; readIn = 1'b0; noMEMIn = 1'b0;
    endtask

    task automatic check_wb(input bit has_wb);
        wb_t w;
        if (has_wb) begin
            w = wb_q.pop_front();
            check("wb_value", wbValueOut, w.val);
            check("wb_rd", 32'(wbRdOut), 32'(w.rd));
            check("wb_en", 32'(wbEnOut), 32'd1);
        end else begin
            check("wb_en_off", 32'(wbEnOut), 32'd0);
        end
    endtask

    // Drives one memory op and serves every queued beat, then checks the writeback.
    task automatic run_op(input logic we, input logic re, input logic [2:0] mode,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input bit has_wb);
        beat_t b;
        @(negedge clk);
        drive_op(we, re, mode, addr, data, rd);
        #1;
        check("accept_stall", 32'(stallOut), 32'd1);
        b = beat_q[0];
        check("accept_req", 32'(memReq), 32'd1);
        check("accept_addr", memAddr, b.addr);
        check("accept_be", 32'(memByteEn), 32'(b.be));
        @(negedge clk);
        while (beat_q.size() > 0) begin
            b = beat_q.pop_front();
            for (int w = 0; w <= b.waits; w++) begin
                #1;
                check("beat_req", 32'(memReq), 32'd1);
                check("beat_stall", 32'(stallOut), 32'd1);
                check("beat_addr", memAddr, b.addr);
                check("beat_be", 32'(memByteEn), 32'(b.be));
                check("beat_we", 32'(memWe), 32'(b.we));
                check("beat_wdata", memWdata & b.wmask, b.wdata);
                if (w == b.waits) begin
                    memAck = 1'b1;
                    memRdata = b.rdata;
                end
                @(negedge clk);
                memAck = 1'b0;
                memRdata = 32'h0;
            end
        end
        #1;
        check("done_stall", 32'(stallOut), 32'd0);
        check("done_req", 32'(memReq), 32'd0);
        bubble();
        @(negedge clk);
        #1;
        check_wb(has_wb);
    endtask

    // Trapped word-crossing access: no request, fault pulse the next cycle, no writeback.
    task automatic run_trap(input logic we, input logic re, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] rd);
        @(negedge clk);
        drive_op(we, re, mode, addr, data, rd);
        #1;
        check("trap_req0", 32'(memReq), 32'd0);
        check("trap_stall0", 32'(stallOut), 32'd1);
        @(negedge clk);
        #1;
        check("trap_fault", 32'(faultOut), 32'd1);
        check("trap_stall1", 32'(stallOut), 32'd0);
        check("trap_req1", 32'(memReq), 32'd0);
        bubble();
        @(negedge clk);
        #1;
        check("trap_fault_end", 32'(faultOut), 32'd0);
        check("trap_wb_en", 32'(wbEnOut), 32'd0);
    endtask

    int n;

    initial begin
        reset = 1'b1;
        bubble();
        valueIn = 32'h0; addressIn = 32'h0; addressModeIn = 3'd0; rdIn = 5'd0;
        memRdata = 32'h0; memAck = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(memReq), 32'd0);
        check("rst_stall", 32'(stallOut), 32'd0);
        check("rst_wb_en", 32'(wbEnOut), 32'd0);
        check("rst_wb_value", wbValueOut, 32'h0);
        check("rst_fault", 32'(faultOut), 32'd0);
        reset = 1'b0;

        // Pass-through, latency 1, never stalls.
        @(negedge clk);
        noMEMIn = 1'b1; valueIn = 32'h1234; rdIn = 5'd5;
        push_wb(32'h1234, 5'd5);
        #1;
        check("pass_stall", 32'(stallOut), 32'd0);
        check("pass_req", 32'(memReq), 32'd0);
        @(negedge clk);
        noMEMIn = 1'b1; valueIn = 32'h9999; rdIn = 5'd0;
        #1;
        check_wb(1);
        check("pass_rd0_stall", 32'(stallOut), 32'd0);
        @(negedge clk);
        bubble();
        #1;
        check("pass_rd0_en", 32'(wbEnOut), 32'd0);
        @(negedge clk);
        #1;
        check("bubble_en", 32'(wbEnOut), 32'd0);

        // LB / LBU at 0x103, two ack waits.
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h0, 32'h80FFFFFF, 2);
        push_wb(32'hFFFFFF80, 5'd6);
        run_op(1'b0, 1'b1, 3'd0, 32'h103, 32'h0, 5'd6, 1);
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h0, 32'h80FFFFFF, 2);
        push_wb(32'h00000080, 5'd6);
        run_op(1'b0, 1'b1, 3'd4, 32'h103, 32'h0, 5'd6, 1);

`ifdef MISALIGN_TRAP_EN
        run_trap(1'b1, 1'b0, 3'd2, 32'h202, 32'hAABBCCDD, 5'd1);
        run_trap(1'b0, 1'b1, 3'd2, 32'h001, 32'h0, 5'd9);
        run_trap(1'b0, 1'b1, 3'd1, 32'h003, 32'h0, 5'd10);
`else
        // Split SW at 0x202.
        push_beat(32'h200, 4'b1100, 1'b1, 32'hCCDD0000, 32'hFFFF0000, 32'h0, 0);
        push_beat(32'h204, 4'b0011, 1'b1, 32'h0000AABB, 32'h0000FFFF, 32'h0, 1);
        run_op(1'b1, 1'b0, 3'd2, 32'h202, 32'hAABBCCDD, 5'd1, 0);
        // Split LW at 0x1.
        push_beat(32'h000, 4'b1110, 1'b0, 32'h0, 32'h0, 32'h44332211, 0);
        push_beat(32'h004, 4'b0001, 1'b0, 32'h0, 32'h0, 32'h88776655, 0);
        push_wb(32'h55443322, 5'd9);
        run_op(1'b0, 1'b1, 3'd2, 32'h001, 32'h0, 5'd9, 1);
        // Split LH at 0x3, sign-extended.
        push_beat(32'h000, 4'b1000, 1'b0, 32'h0, 32'h0, 32'hCD000000, 1);
        push_beat(32'h004, 4'b0001, 1'b0, 32'h0, 32'h0, 32'h000000AB, 0);
        push_wb(32'hFFFFABCD, 5'd10);
        run_op(1'b0, 1'b1, 3'd1, 32'h003, 32'h0, 5'd10, 1);
`endif

        // SB at 0x101 (noMEMIn also set: write wins).
        push_beat(32'h100, 4'b0010, 1'b1, 32'h00005500, 32'h0000FF00, 32'h0, 0);
        @(negedge clk);
        noMEMIn = 1'b1;
        run_op(1'b1, 1'b0, 3'd0, 32'h101, 32'h11223355, 5'd3, 0);
        // SH at 0x102.
        push_beat(32'h100, 4'b1100, 1'b1, 32'h12340000, 32'hFFFF0000, 32'h0, 0);
        run_op(1'b1, 1'b0, 3'd1, 32'h102, 32'h99991234, 5'd3, 0);
        // Store func3=4 is a word.
        push_beat(32'h300, 4'b1111, 1'b1, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h0, 0);
        run_op(1'b1, 1'b0, 3'd4, 32'h300, 32'hCAFEF00D, 5'd3, 0);
        // LHU / LH at offset 2.
        push_beat(32'h010, 4'b1100, 1'b0, 32'h0, 32'h0, 32'hF00D1234, 0);
        push_wb(32'h0000F00D, 5'd12);
        run_op(1'b0, 1'b1, 3'd5, 32'h012, 32'h0, 5'd12, 1);
        push_beat(32'h010, 4'b1100, 1'b0, 32'h0, 32'h0, 32'hF00D1234, 3);
        push_wb(32'hFFFFF00D, 5'd13);
        run_op(1'b0, 1'b1, 3'd1, 32'h012, 32'h0, 5'd13, 1);
        // Load func3=3 is a word.
        push_beat(32'h020, 4'b1111, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 0);
        push_wb(32'hDEADBEEF, 5'd31);
        run_op(1'b0, 1'b1, 3'd3, 32'h020, 32'h0, 5'd31, 1);
        // Load to x0: no writeback.
        push_beat(32'h024, 4'b1111, 1'b0, 32'h0, 32'h0, 32'h12345678, 0);
        run_op(1'b0, 1'b1, 3'd2, 32'h024, 32'h0, 5'd0, 0);

        // Ack timeout on LH at 0x10.
        @(negedge clk);
        drive_op(1'b0, 1'b1, 3'd1, 32'h010, 32'h0, 5'd4);
        #1;
        check("to_req", 32'(memReq), 32'd1);
        check("to_be", 32'(memByteEn), 32'h3);
        @(negedge clk);
        n = 0;
        while (faultOut !== 1'b1 && n < MAXW + 8) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("to_cycles", 32'(n), 32'(MAXW));
        check("to_fault", 32'(faultOut), 32'd1);
        check("to_stall", 32'(stallOut), 32'd0);
        check("to_req_drop", 32'(memReq), 32'd0);
        check("to_wb_en", 32'(wbEnOut), 32'd0);
        bubble();
        @(negedge clk);
        #1;
        check("to_fault_end", 32'(faultOut), 32'd0);
        check("to_wb_en2", 32'(wbEnOut), 32'd0);

        // Reset while in BEAT0, then a late ack.
        @(negedge clk);
        drive_op(1'b0, 1'b1, 3'd2, 32'h040, 32'h0, 5'd7);
        @(negedge clk);
        #1;
        check("rm_req", 32'(memReq), 32'd1);
        reset = 1'b1;
        bubble();
        @(negedge clk);
        #1;
        check("rm_req_drop", 32'(memReq), 32'd0);
        check("rm_stall", 32'(stallOut), 32'd0);
        check("rm_wb_en", 32'(wbEnOut), 32'd0);
        reset = 1'b0;
        memAck = 1'b1;
        memRdata = 32'h5A5A5A5A;
        #1;
        check("rm_late_req", 32'(memReq), 32'd0);
        @(negedge clk);
        memAck = 1'b0;
        #1;
        check("rm_late_wb_en", 32'(wbEnOut), 32'd0);
        check("rm_late_stall", 32'(stallOut), 32'd0);
        check("rm_late_fault", 32'(faultOut), 32'd0);

        // Normal operation resumes.
        push_beat(32'h050, 4'b1111, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 0);
        push_wb(32'h0BADF00D, 5'd8);
        run_op(1'b0, 1'b1, 3'd2, 32'h050, 32'h0, 5'd8, 1);

        check("sb_beats_left", 32'(beat_q.size()), 32'd0);
        check("sb_wb_left", 32'(wb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
